register_bank: RTL and testbench

- Parametrised successor to the fixed four-register GPR group.
- Holds NREGS registers of WIDTH bits, loaded from the shared data bus on the clock edge.
- Any drive-capable register can be placed on the bus through a select field.
- Adds in-place increment/decrement on one selected register with a registered wrap pulse; this supports index/loop counters without an ALU round-trip.

---
 rtl/register_bank_if.sv | 21 ++
 rtl/register_bank.sv | 61 ++++++
 tb/tb_register_bank.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/register_bank_if.sv
// register_bank_if: control/status bundle for register_bank; the shared dbus stays a plain inout port.
interface register_bank_if #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  parameter int SELW = 2
);
  logic [NREGS-1:0] loadEn;
  logic assertEn;
  logic [SELW-1:0] assertSel;
  logic incEn;
  logic decEn;
  logic [SELW-1:0] cntSel;
  logic [NREGS*WIDTH-1:0] regs;
  logic wrap;
  logic driveFault;
  logic [NREGS-1:0] zeroFlags;
  modport master (output loadEn, assertEn, assertSel, incEn, decEn, cntSel,
                  input regs, wrap, driveFault, zeroFlags);
  modport slave (input loadEn, assertEn, assertSel, incEn, decEn, cntSel,
                 output regs, wrap, driveFault, zeroFlags);
endinterface

// File: rtl/register_bank.sv
// register_bank: NREGS x WIDTH bus-loaded registers with masked bus drive and in-place inc/dec with wrap pulse.
// Optional registered per-register zero flags when REGBANK_ZERO_FLAGS_EN is defined.
module register_bank #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  parameter int SELW = 2,
  parameter logic [15:0] DRIVEMASK = 16'h0005
) (
  input logic clk,
  input logic reset,
  register_bank_if.slave bus,
  inout wire [WIDTH-1:0] dbus
);
  logic [WIDTH-1:0] r [NREGS];
  logic [WIDTH-1:0] nxt [NREGS];
  logic [NREGS*WIDTH-1:0] regsFlat;
  logic canDrive;
  logic cntOk;
  logic wrapNext;
  logic wrapQ;
  assign canDrive = bus.assertEn && int'(bus.assertSel) < NREGS && DRIVEMASK[bus.assertSel];
  assign dbus = canDrive ? r[bus.assertSel] : 'z;
  assign bus.driveFault = bus.assertEn & ~canDrive;
  // A load to the count target wins and silently drops the count.
  assign cntOk = (bus.incEn ^ bus.decEn) && int'(bus.cntSel) < NREGS && !bus.loadEn[bus.cntSel];
  always_comb begin
    wrapNext = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      nxt[i] = bus.loadEn[i] ? dbus : r[i];
      if (cntOk && bus.cntSel == SELW'(i)) begin
        nxt[i] = bus.incEn ? r[i] + WIDTH'(1) : r[i] - WIDTH'(1);
        wrapNext = bus.incEn ? &r[i] : ~|r[i];
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r[i] <= '0;
      wrapQ <= 1'b0;
    end else begin
      r <= nxt;
      wrapQ <= wrapNext;
    end
  end
  always_comb begin
    regsFlat = '0;
    for (int i = 0; i < NREGS; i++) regsFlat[i*WIDTH +: WIDTH] = r[i];
  end
  assign bus.regs = regsFlat;
  assign bus.wrap = wrapQ;
`ifdef REGBANK_ZERO_FLAGS_EN
  logic [NREGS-1:0] zf;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) zf <= '1;
    else for (int i = 0; i < NREGS; i++) zf[i] <= nxt[i] == '0;
  end
  assign bus.zeroFlags = zf;
`else
  assign bus.zeroFlags = '0;
`endif
endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: directed checks of load, drive, count/wrap, priority, async reset and a narrow parameter set.
module tb_register_bank;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  logic tbDrv = 1'b0;
  logic [7:0] tbVal = '0;
  logic tbDrvB = 1'b0;
  logic [3:0] tbValB = '0;
  wire [7:0] dbus;
  wire [3:0] dbusB;
  register_bank_if #(.WIDTH(8), .NREGS(4), .SELW(2)) ifA ();
  register_bank_if #(.WIDTH(4), .NREGS(3), .SELW(2)) ifB ();
  register_bank dutA (.clk(clk), .reset(reset), .bus(ifA.slave), .dbus(dbus));
  register_bank #(.WIDTH(4), .NREGS(3), .SELW(2), .DRIVEMASK(16'h0007)) dutB (
    .clk(clk), .reset(reset), .bus(ifB.slave), .dbus(dbusB));
  assign dbus = tbDrv ? tbVal : 'z;
  assign dbusB = tbDrvB ? tbValB : 'z;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [7:0] ra(input int i);
    return ifA.regs[i*8 +: 8];
  endfunction
  initial begin
    {ifA.loadEn, ifA.assertEn, ifA.assertSel, ifA.incEn, ifA.decEn, ifA.cntSel} = '0;
    {ifB.loadEn, ifB.assertEn, ifB.assertSel, ifB.incEn, ifB.decEn, ifB.cntSel} = '0;
    tick;
    check("rst_regs", ifA.regs, 32'h0);
    check("rst_wrap", ifA.wrap, 0);
`ifdef REGBANK_ZERO_FLAGS_EN
    check("rst_zf", ifA.zeroFlags, 4'b1111);
`else
    check("rst_zf", ifA.zeroFlags, 0);
`endif
    reset = 1'b0;
    tbDrv = 1; tbVal = 8'h5A; ifA.loadEn = 4'b0101;
    tick;
    tbDrv = 0; ifA.loadEn = '0;
    check("load_r0", ra(0), 8'h5A);
    check("load_r1", ra(1), 8'h00);
    check("load_r2", ra(2), 8'h5A);
    ifA.assertEn = 1; ifA.assertSel = 2;
    #1;
    check("drv2_bus", dbus, 8'h5A);
    check("drv2_fault", ifA.driveFault, 0);
    ifA.assertSel = 1; tbDrv = 1; tbVal = 8'hC3;
    #1;
    check("drv1_free", dbus, 8'hC3);
    check("drv1_fault", ifA.driveFault, 1);
    ifA.assertSel = 3;
    #1;
    check("drv3_fault", ifA.driveFault, 1);
    tbDrv = 0; ifA.assertSel = 0; ifA.loadEn = 4'b1001;
    tick;
    ifA.loadEn = '0; ifA.assertEn = 0;
    check("hold_r0", ra(0), 8'h5A);
    check("bcast_r3", ra(3), 8'h5A);
    #1;
    check("idle_fault", ifA.driveFault, 0);
    tbDrv = 1; tbVal = 8'hFE; ifA.loadEn = 4'b0100;
    tick;
    tbDrv = 0; ifA.loadEn = '0; ifA.incEn = 1; ifA.cntSel = 2;
    tick;
    check("inc_ff", ra(2), 8'hFF);
    check("inc_ff_wrap", ifA.wrap, 0);
    tick;
    ifA.incEn = 0;
    check("inc_00", ra(2), 8'h00);
    check("inc_wrap", ifA.wrap, 1);
`ifdef REGBANK_ZERO_FLAGS_EN
    check("inc_zf", ifA.zeroFlags, 4'b0110);
`endif
    tick;
    check("inc_wrap_clr", ifA.wrap, 0);
    check("inc_hold", ra(2), 8'h00);
    tbDrv = 1; tbVal = 8'h00; ifA.loadEn = 4'b1000;
    tick;
    tbDrv = 0; ifA.loadEn = '0; ifA.decEn = 1; ifA.cntSel = 3;
    tick;
    check("dec_ff", ra(3), 8'hFF);
    check("dec_wrap", ifA.wrap, 1);
    ifA.incEn = 1;
    tick;
    ifA.incEn = 0; ifA.decEn = 0;
    check("conf_hold", ra(3), 8'hFF);
    check("conf_wrap", ifA.wrap, 0);
    tbDrv = 1; tbVal = 8'hFF; ifA.loadEn = 4'b0001;
    tick;
    tbVal = 8'h33; ifA.loadEn = 4'b0011; ifA.incEn = 1; ifA.cntSel = 0;
    tick;
    check("ldpri_r0", ra(0), 8'h33);
    check("ldpri_r1", ra(1), 8'h33);
    check("ldpri_wrap", ifA.wrap, 0);
    tbVal = 8'h77; ifA.loadEn = 4'b0010; ifA.cntSel = 2;
    tick;
    tbDrv = 0; ifA.loadEn = '0;
    check("indep_r1", ra(1), 8'h77);
    check("indep_r2", ra(2), 8'h01);
    ifA.incEn = 0; ifA.decEn = 1; ifA.cntSel = 2;
    tick;
    check("pre_rst_r2", ra(2), 8'h00);
    #2 reset = 1'b1;
    #1;
    check("arst_regs", ifA.regs, 32'h0);
    check("arst_wrap", ifA.wrap, 0);
    tick;
    check("arst_hold_wrap", ifA.wrap, 0);
    @(negedge clk);
    reset = 1'b0; ifA.decEn = 0;
    tick;
    check("post_rst_wrap", ifA.wrap, 0);
    check("post_rst_regs", ifA.regs, 32'h0);
    tbDrvB = 1; tbValB = 4'hF; ifB.loadEn = 3'b010;
    tick;
    tbDrvB = 0; ifB.loadEn = '0;
    check("b_load", ifB.regs, 12'h0F0);
    ifB.incEn = 1; ifB.cntSel = 3;
    tick;
    check("b_oor_inc", ifB.regs, 12'h0F0);
    check("b_oor_wrap", ifB.wrap, 0);
    ifB.incEn = 0; ifB.assertEn = 1; ifB.assertSel = 3; tbDrvB = 1; tbValB = 4'h5;
    #1;
    check("b_oor_bus", dbusB, 4'h5);
    check("b_oor_fault", ifB.driveFault, 1);
    tbDrvB = 0; ifB.assertSel = 1;
    #1;
    check("b_drv1", dbusB, 4'hF);
    check("b_drv1_fault", ifB.driveFault, 0);
    ifB.assertEn = 0; ifB.incEn = 1; ifB.cntSel = 1;
    tick;
    ifB.incEn = 0;
    check("b_wrap_reg", ifB.regs, 12'h000);
    check("b_wrap", ifB.wrap, 1);
    tick;
    check("b_wrap_clr", ifB.wrap, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
